// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline chain.
package pipe_pkg;

  // Width needed to count 0..depth inclusive; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline stage: a valid bit and a payload register with load/hold,
// synchronous flush and synchronous active-low reset.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_prev_valid,
  input  logic [WIDTH-1:0] i_prev_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_nxt_valid
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_nxt_valid;

  // Next valid is exported so the parent can count occupancy without re-deriving it.
  always_comb begin
    w_nxt_valid = r_valid;
    if (!i_rst_n) begin
      w_nxt_valid = 1'b0;
    end else if (i_flush) begin
      w_nxt_valid = 1'b0;
    end else if (i_load) begin
      w_nxt_valid = i_prev_valid;
    end else begin
      w_nxt_valid = r_valid;
    end
  end

  // Valid register follows the precomputed next state.
  always_ff @(posedge clk_i) begin
    r_valid <= w_nxt_valid;
  end

  // Payload only moves with a real beat so bubbles leave stale data untouched.
  always_ff @(posedge clk_i) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (!i_flush && i_load && i_prev_valid) begin
      r_data <= i_prev_data;
    end else begin
      r_data <= r_data;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_nxt_valid = w_nxt_valid;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline of DEPTH valid/data stages with combinational back-pressure,
// global stall (en) and synchronous flush; tracks a registered occupancy count.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_nxt_valid;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_prev_valid;
  logic [WIDTH-1:0] w_data      [DEPTH];
  logic [WIDTH-1:0] w_prev_data [DEPTH];
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] r_occupancy;
  logic             w_tail_full;

  // Stage k can advance when any stage from k to the output is empty or the output drains.
  always_comb begin
    w_tail_full = 1'b1;
    w_rdy       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_tail_full = w_tail_full & w_valid[k];
      w_rdy[k]    = ~w_tail_full | out_ready;
    end
  end

  // Each stage is fed by its predecessor; stage 0 is fed by the upstream port.
  always_comb begin
    w_prev_valid    = '0;
    w_prev_valid[0] = in_valid;
    w_prev_data[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_prev_valid[k] = w_valid[k-1];
      w_prev_data[k]  = w_data[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipe_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk_i       (clk_i),
      .i_rst_n     (reset),
      .i_flush     (flush),
      .i_load      (en & ~flush & w_rdy[k]),
      .i_prev_valid(w_prev_valid[k]),
      .i_prev_data (w_prev_data[k]),
      .o_valid     (w_valid[k]),
      .o_data      (w_data[k]),
      .o_nxt_valid (w_nxt_valid[k])
    );
  end

  // Popcount of next-state valid bits; bounded by DEPTH by construction.
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_cnt = w_cnt + CNT_W'(w_nxt_valid[k]);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      r_occupancy <= '0;
    end else begin
      r_occupancy <= w_cnt;
    end
  end

  assign in_ready  = w_rdy[0] & en & ~flush & reset;
  assign out_valid = w_valid[DEPTH-1] & en & ~flush;
  assign out_data  = w_data[DEPTH-1];
  assign occupancy = r_occupancy;

endmodule
